// File: rtl/mips_debug_sequencer.sv
// UART-driven run controller for the MIPS core: program load, run/step clock gating, bucket dump.
// Optional watchdog on continuous runs is enabled with `define RUN_CYCLE_LIMIT_EN.
module mips_debug_sequencer #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int len_data      = 32,
  parameter int len_addr      = 7,
  parameter int len_bucket    = 640,
  parameter int len_contador  = $clog2(len_bucket/8),
  parameter logic [len_data-1:0] MAX_RUN_CYCLES = 32'h00FF_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  input  logic                     tx_done_tick,
  input  logic                     halt,
  input  logic [len_bucket-1:0]    bucket,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] data_out,
  output logic                     ctrl_clk_mips,
  output logic                     debug,
  output logic                     wr_ram_inst,
  output logic [len_addr-1:0]      addr_mem_inst,
  output logic [len_data-1:0]      ins_to_mem,
  output logic [len_data-1:0]      out_clk_counter
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, RUN,
    STEP_WAIT, STEP_TICK, DUMP_SEND, DUMP_WAIT
  } state_t;

  localparam logic [NBIT_DATA_LEN-1:0] CMD_L = NBIT_DATA_LEN'(8'h4C);
  localparam logic [NBIT_DATA_LEN-1:0] CMD_C = NBIT_DATA_LEN'(8'h43);
  localparam logic [NBIT_DATA_LEN-1:0] CMD_S = NBIT_DATA_LEN'(8'h53);
  localparam logic [NBIT_DATA_LEN-1:0] CMD_N = NBIT_DATA_LEN'(8'h4E);
  localparam logic [NBIT_DATA_LEN-1:0] CMD_E = NBIT_DATA_LEN'(8'h45);
  localparam logic [len_contador-1:0] IDX_LAST =
    len_contador'(len_bucket/8 - 1);

  state_t                  state_q, state_d;
  state_t                  ret_q, ret_d;
  logic [len_addr-1:0]     addr_q, addr_d;
  logic [len_data-1:0]     ins_q, ins_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [len_contador-1:0] idx_q, idx_d;
  logic [len_data-1:0]     cnt_q, cnt_d;
  logic                    limit;

`ifdef RUN_CYCLE_LIMIT_EN
  assign limit = (cnt_q >= MAX_RUN_CYCLES);
`else
  logic unused_max;
  assign unused_max = ^MAX_RUN_CYCLES;
  assign limit      = 1'b0;
`endif

  // Clock enable is combinational so a rising halt blocks the very next MIPS edge
  assign ctrl_clk_mips = (state_q == RUN && !halt && !limit) ||
                         (state_q == STEP_TICK);
  assign tx_start      = (state_q == DUMP_SEND);
  assign data_out      = tx_start ?
                         bucket[NBIT_DATA_LEN*idx_q +: NBIT_DATA_LEN] : '0;
  assign debug         = (state_q == STEP_WAIT);
  assign wr_ram_inst   = (state_q == WRITE);
  assign addr_mem_inst   = addr_q;
  assign ins_to_mem      = ins_q;
  assign out_clk_counter = cnt_q;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    addr_d  = addr_q;
    ins_d   = ins_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (ctrl_clk_mips && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          if (rx_data_in == CMD_L) begin
            addr_d  = '0;
            bcnt_d  = '0;
            cnt_d   = '0;
            state_d = LOAD;
          end else if (rx_data_in == CMD_C) begin
            state_d = RUN;
          end else if (rx_data_in == CMD_S) begin
            state_d = STEP_WAIT;
          end
        end
      end
      LOAD: begin
        if (rx_done_tick) begin
          ins_d  = {ins_q[len_data-NBIT_DATA_LEN-1:0], rx_data_in};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3)
            state_d = WRITE;
        end
      end
      WRITE: begin
        if (ins_q == '1 || addr_q == '1) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LOAD;
        end
      end
      RUN: begin
        if (halt || limit) begin
          ret_d   = IDLE;
          state_d = DUMP_SEND;
        end
      end
      STEP_WAIT: begin
        if (rx_done_tick) begin
          if (rx_data_in == CMD_N)
            state_d = STEP_TICK;
          else if (rx_data_in == CMD_E)
            state_d = IDLE;
        end
      end
      STEP_TICK: begin
        ret_d   = halt ? IDLE : STEP_WAIT;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        if (tx_done_tick) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ret_q;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DUMP_SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      addr_q  <= '0;
      ins_q   <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      addr_q  <= addr_d;
      ins_q   <= ins_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_debug_sequencer.sv
// Scoreboard bench for mips_debug_sequencer: load, run, step, wrap, reset mid-dump.
// Build with RUN_CYCLE_LIMIT_EN defined to also exercise the run watchdog.
module tb_mips_debug_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_done_tick = 1'b0;
  logic [7:0]   rx_data_in = 8'h00;
  logic         tx_done_tick = 1'b0;
  logic         halt = 1'b0;
  logic [639:0] bucket;
  logic         tx_start;
  logic [7:0]   data_out;
  logic         ctrl_clk_mips;
  logic         debug;
  logic         wr_ram_inst;
  logic [6:0]   addr_mem_inst;
  logic [31:0]  ins_to_mem;
  logic [31:0]  out_clk_counter;

  mips_debug_sequencer #(.MAX_RUN_CYCLES(32'd100)) dut (
    .clk(clk), .reset(reset),
    .rx_done_tick(rx_done_tick), .rx_data_in(rx_data_in),
    .tx_done_tick(tx_done_tick), .halt(halt), .bucket(bucket),
    .tx_start(tx_start), .data_out(data_out),
    .ctrl_clk_mips(ctrl_clk_mips), .debug(debug),
    .wr_ram_inst(wr_ram_inst), .addr_mem_inst(addr_mem_inst),
    .ins_to_mem(ins_to_mem), .out_clk_counter(out_clk_counter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  int clk_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  initial begin
    for (int k = 0; k < 80; k++) bucket[8*k +: 8] = pat(k);
  end

  // Monitor: pops expected writes / bytes whenever the DUT presents them
  always @(negedge clk) begin
    if (ctrl_clk_mips === 1'b1) clk_pulses++;
    if (wr_ram_inst === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {25'd0, addr_mem_inst, ins_to_mem}, 64'd0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 64'(addr_mem_inst), 64'(e.a));
        chk("wr_data", 64'(ins_to_mem), 64'(e.d));
      end
    end
    if (tx_start === 1'b1) begin
      tx_seen++;
      if (tx_q.size() == 0)
        chk("unexpected_tx", 64'(data_out), 64'hFFFF);
      else
        chk("tx_byte", 64'(data_out), 64'(tx_q.pop_front()));
    end
  end

  // UART transmitter model: acknowledges each byte a few cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 tx_done_tick = 1'b1;
        @(posedge clk);
        #1 tx_done_tick = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data_in = b;
    rx_done_tick = 1'b1;
    @(posedge clk);
    #1 rx_done_tick = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_dump(input int n);
    for (int k = 0; k < n; k++) tx_q.push_back(pat(k));
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (tx_q.size() == 0 && wr_q.size() == 0) break;
    end
    if (i == budget) chk("drain_timeout", 64'(tx_q.size()), 64'd0);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    wr_t w;
    int base;
    int i;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_ctrl_clk", 64'(ctrl_clk_mips), 64'd0);
    chk("rst_debug", 64'(debug), 64'd0);
    chk("rst_wr", 64'(wr_ram_inst), 64'd0);
    chk("rst_addr", 64'(addr_mem_inst), 64'd0);
    chk("rst_ins", 64'(ins_to_mem), 64'd0);
    chk("rst_counter", 64'(out_clk_counter), 64'd0);

    // Load two words, the second is the halt opcode
    w.a = 7'd0; w.d = 32'h2001_0005; wr_q.push_back(w);
    w.a = 7'd1; w.d = 32'hFFFF_FFFF; wr_q.push_back(w);
    send_byte(8'h4C);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    wait_drain(50);

    // Continuous run: halt after 10 enabled cycles
    clk_pulses = 0;
    push_dump(80);
    send_byte(8'h43);
    repeat (10) @(posedge clk);
    #1 halt = 1'b1;
    @(negedge clk);
    chk("run_halt_gate", 64'(ctrl_clk_mips), 64'd0);
    wait_drain(2000);
    chk("run_counter", 64'(out_clk_counter), 64'd10);
    chk("run_pulses", 64'(clk_pulses), 64'd10);
    halt = 1'b0;

    // Clear counter via a one-word load, then step twice
    w.a = 7'd0; w.d = 32'hFFFF_FFFF; wr_q.push_back(w);
    send_byte(8'h4C);
    send_word(32'hFFFF_FFFF);
    wait_drain(50);
    chk("load_clears_cnt", 64'(out_clk_counter), 64'd0);
    clk_pulses = 0;
    send_byte(8'h53);
    @(negedge clk);
    chk("step_debug", 64'(debug), 64'd1);
    for (int s = 1; s <= 2; s++) begin
      push_dump(80);
      send_byte(8'h4E);
      wait_drain(2000);
      chk("step_pulses", 64'(clk_pulses), 64'(s));
      chk("step_debug_back", 64'(debug), 64'd1);
    end
    chk("step_counter", 64'(out_clk_counter), 64'd2);
    send_byte(8'h45);
    @(negedge clk);
    chk("exit_debug", 64'(debug), 64'd0);

    // Step with halt high returns to IDLE after the dump
    send_byte(8'h53);
    halt = 1'b1;
    push_dump(80);
    send_byte(8'h4E);
    wait_drain(2000);
    chk("step_halt_debug", 64'(debug), 64'd0);
    chk("step_halt_cnt", 64'(out_clk_counter), 64'd3);
    halt = 1'b0;

    // Address wrap: 128 non-halt words, the 129th is not loaded
    for (int a = 0; a < 128; a++) begin
      w.a = 7'(a); w.d = 32'h1000_0000 + 32'(a); wr_q.push_back(w);
    end
    send_byte(8'h4C);
    for (int a = 0; a < 128; a++) send_word(32'h1000_0000 + 32'(a));
    send_word(32'h1122_3344);
    wait_drain(100);
    chk("wrap_wr_low", 64'(wr_ram_inst), 64'd0);
    chk("wrap_counter", 64'(out_clk_counter), 64'd0);

    // Reset in the middle of a dump
    halt = 1'b1;
    base = tx_seen;
    push_dump(5);
    send_byte(8'h43);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_seen == base + 2) break;
    end
    send_byte(8'h4E);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_seen == base + 5) break;
    end
    if (i == 200) chk("mid_dump_timeout", 64'(tx_seen - base), 64'd5);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 64'(tx_start), 64'd0);
    chk("mid_rst_debug", 64'(debug), 64'd0);
    chk("mid_rst_cnt", 64'(out_clk_counter), 64'd0);
    chk("mid_rst_q", 64'(tx_q.size()), 64'd0);
    repeat (10) @(posedge clk);
    push_dump(80);
    send_byte(8'h43);
    wait_drain(2000);
    chk("rerun_cnt", 64'(out_clk_counter), 64'd0);
    halt = 1'b0;

`ifdef RUN_CYCLE_LIMIT_EN
    w.a = 7'd0; w.d = 32'hFFFF_FFFF; wr_q.push_back(w);
    send_byte(8'h4C);
    send_word(32'hFFFF_FFFF);
    wait_drain(50);
    clk_pulses = 0;
    push_dump(80);
    send_byte(8'h43);
    wait_drain(3000);
    chk("wd_counter", 64'(out_clk_counter), 64'd100);
    chk("wd_pulses", 64'(clk_pulses), 64'd100);
`endif

    chk("end_wr_q", 64'(wr_q.size()), 64'd0);
    chk("end_tx_q", 64'(tx_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
